usb_line_state_monitor: RTL and testbench
=========================================

Name: usb_line_state_monitor

Overview:
- Clocked, parametrised successor to the combinational USB line decoder.
- Synchronises and deglitches usb_dp/usb_dn, decodes the line symbol (SE0/J/K/SE1) with speed-dependent J/K polarity, and detects bus conditions: EOP, bus reset, suspend and resume.
- Sits between the PHY pads and the SIE/link controller; all outputs are in the clk domain.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per line, minimum 2.
- FILTER_CYCLES, 3: consecutive cycles a new raw state must persist before acceptance; 1 means no filtering.
- LOW_SPEED, 0: 0 gives FS polarity (J={dp,dn}=2'b10); 1 gives LS polarity (J=2'b01).
- EOP_MAX_CYCLES, 8: longest SE0 accepted as an EOP before it is treated as a reset candidate.
- RESET_CYCLES, 120: SE0 duration that asserts bus_reset (2.5 us at 48 MHz).
- SUSPEND_CYCLES, 144000: idle-J duration that asserts suspend (3 ms at 48 MHz).
- CNT_W, $clog2(SUSPEND_CYCLES+1): duration counter width; derived, not overridden.

Ports:
- clk, input, 1: sole clock.
- rst, input, 1: asynchronous, active-high reset.
- usb_dp, input, 1: raw D+ pad, asynchronous.
- usb_dn, input, 1: raw D- pad, asynchronous.
- usb_line_state, output, 2: filtered {dp,dn}. SE0=00, FS-J/LS-K=10, FS-K/LS-J=01, SE1=11.
- line_j, output, 1: filtered state equals J for the selected speed.
- line_k, output, 1: filtered state equals K for the selected speed.
- line_se0, output, 1: filtered state is SE0.
- line_change, output, 1: one-cycle pulse when usb_line_state updates.
- eop, output, 1: one-cycle pulse on the SE0-to-J transition when SE0 lasted 1..EOP_MAX_CYCLES cycles.
- se1_err, output, 1: one-cycle pulse on entry into SE1.
- bus_reset, output, 1: level, asserted while the reset condition holds.
- suspend, output, 1: level, asserted while suspended.
- resume, output, 1: one-cycle pulse on the first K accepted while suspended.

Behaviour:
- Reset (async assert, sync deassert on next clk edge):
  - synchroniser flops = 0; usb_line_state = 2'b00; filter and duration counters = 0; FSM = ST_SE0.
  - line_j/k = 0; line_se0 = 1; all pulses = 0; bus_reset = 0; suspend = 0.
- Synchroniser: SYNC_STAGES-deep chain per line; dp and dn are synchronised independently.
- Filter:
  - Each cycle the synchroniser output differs from usb_line_state, the filter counter increments; any match clears it.
  - On the FILTER_CYCLES-th consecutive mismatch cycle, usb_line_state takes the candidate and line_change pulses in the same cycle.
  - If the candidate changes to a different non-matching value mid-count, the counter restarts at 1.
  - Pin-to-usb_line_state latency is exactly SYNC_STAGES+FILTER_CYCLES clock edges.
- Duration counter: cleared on every line_change, otherwise increments; saturates at SUSPEND_CYCLES and never wraps.
- FSM states: ST_ACTIVE, ST_SE0, ST_RESET, ST_SUSPEND.
  - ST_ACTIVE, SE0 accepted: go to ST_SE0.
  - ST_ACTIVE, J held with counter reaching SUSPEND_CYCLES: suspend=1, go to ST_SUSPEND.
  - ST_SE0, J accepted with prior SE0 count (inclusive) <= EOP_MAX_CYCLES: eop pulse, go to ST_ACTIVE.
  - ST_SE0, J accepted after a longer SE0 (but below RESET_CYCLES): no eop, go to ST_ACTIVE.
  - ST_SE0, K or SE1 accepted: go to ST_ACTIVE, no eop.
  - ST_SE0, counter reaches RESET_CYCLES: bus_reset=1, go to ST_RESET.
  - ST_RESET: bus_reset held until any non-SE0 state is accepted; then bus_reset=0 and go to ST_ACTIVE. No eop pulse on exit.
  - ST_SUSPEND, K accepted: resume pulse, suspend=0, go to ST_ACTIVE.
  - ST_SUSPEND, SE0 accepted: suspend=0, go to ST_SE0, so a reset from suspend is still detected.
- se1_err pulses on any accepted entry into SE1, in any state; the FSM treats SE1 as non-J and non-SE0.
- line_change and eop may pulse in the same cycle; that is the normal case for EOP.
- Reset mid-operation returns to the reset values immediately; no pulse is emitted on reset deassert.
- With the pads held SE0 after reset, bus_reset asserts after RESET_CYCLES. This is intended: a disconnected or reset bus.

Decomposition:
- Package usb_phy_pkg holds:
  - line-state localparams LS_SE0=2'b00, LS_DP=2'b10, LS_DN=2'b01, LS_SE1=2'b11;
  - the FSM state encoding;
  - function j_code(low_speed), returning the J pattern for the selected speed.
- Sub-module usb_sync_filter: parametrised synchroniser plus persistence filter for a 2-bit bus, with outputs state and change.
- The parent holds the duration counter, FSM and outputs.

Test Plan (bench overrides: RESET_CYCLES=16, SUSPEND_CYCLES=64, EOP_MAX_CYCLES=4, FILTER_CYCLES=3, SYNC_STAGES=2):
- Drive dp=1,dn=0 from reset -> usb_line_state=10 and line_j=1 exactly 5 edges later, one line_change pulse; with LOW_SPEED=1 the same drive gives line_k=1.
- Drive a 2-cycle dp glitch (10->00->10) -> usb_line_state never changes and there is no line_change.
- FS J, then SE0 for 3 cycles, then J -> one eop pulse coincident with the J acceptance; a 6-cycle SE0 -> no eop.
- Hold SE0 for 20 cycles -> bus_reset rises once the accepted SE0 has lasted 16 cycles; drive J -> bus_reset falls when J is accepted, no eop.
- Hold idle J for 70 cycles -> suspend=1 once J has lasted 64 cycles; drive K -> one resume pulse, suspend=0, FSM in ST_ACTIVE.
- Drive dp=dn=1 -> one se1_err pulse; assert rst mid-SE0 count -> all outputs at reset values immediately, no bus_reset.

Source files
------------

// File: rtl/usb_phy_pkg.sv
// usb_phy_pkg: line-state codes, monitor FSM encoding and speed-dependent J pattern
package usb_phy_pkg;
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_DP  = 2'b10;
  localparam logic [1:0] LS_DN  = 2'b01;
  localparam logic [1:0] LS_SE1 = 2'b11;
  localparam logic [1:0] ST_ACTIVE  = 2'd0;
  localparam logic [1:0] ST_SE0     = 2'd1;
  localparam logic [1:0] ST_RESET   = 2'd2;
  localparam logic [1:0] ST_SUSPEND = 2'd3;
  function automatic logic [1:0] j_code(input logic low_speed);
    return low_speed ? LS_DN : LS_DP;
  endfunction
endpackage

// File: rtl/usb_sync_filter.sv
// usb_sync_filter: per-line synchroniser chain plus persistence filter on the 2-bit line bus
module usb_sync_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_line,
  output logic [1:0] o_state,
  output logic       o_change
);
  import usb_phy_pkg::*;
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  logic [SYNC_STAGES-1:0] r_sync_dp, r_sync_dn;
  logic [1:0] r_state, r_cand;
  logic [FW-1:0] r_cnt;
  logic r_change;
  logic [1:0] w_raw;
  logic [FW-1:0] w_next;
  logic w_accept;
  // a candidate differing from the one being counted restarts the count at 1
  always_comb begin
    w_raw = {r_sync_dp[SYNC_STAGES-1], r_sync_dn[SYNC_STAGES-1]};
    w_next = (r_cnt != '0 && w_raw == r_cand) ? r_cnt + FW'(1) : FW'(1);
    w_accept = w_raw != r_state && w_next == FW'(FILTER_CYCLES);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync_dp <= '0;
      r_sync_dn <= '0;
      r_state <= LS_SE0;
      r_cand <= LS_SE0;
      r_cnt <= '0;
      r_change <= 1'b0;
    end else begin
      r_sync_dp <= {r_sync_dp[SYNC_STAGES-2:0], i_line[1]};
      r_sync_dn <= {r_sync_dn[SYNC_STAGES-2:0], i_line[0]};
      r_change <= w_accept;
      r_cnt <= (w_raw == r_state || w_accept) ? '0 : w_next;
      if (w_raw != r_state) r_cand <= w_raw;
      if (w_accept) r_state <= w_raw;
    end
  assign o_state = r_state;
  assign o_change = r_change;
endmodule

// File: rtl/usb_line_state_monitor.sv
// usb_line_state_monitor: filtered USB line decoder with EOP, bus reset, suspend and resume detection
module usb_line_state_monitor #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 3,
  parameter bit LOW_SPEED      = 1'b0,
  parameter int EOP_MAX_CYCLES = 8,
  parameter int RESET_CYCLES   = 120,
  parameter int SUSPEND_CYCLES = 144000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       usb_dp,
  input  logic       usb_dn,
  output logic [1:0] usb_line_state,
  output logic       line_j,
  output logic       line_k,
  output logic       line_se0,
  output logic       line_change,
  output logic       eop,
  output logic       se1_err,
  output logic       bus_reset,
  output logic       suspend,
  output logic       resume
);
  import usb_phy_pkg::*;
  localparam int CNT_W = $clog2(SUSPEND_CYCLES + 1);
  localparam logic [1:0] J_CODE = j_code(LOW_SPEED);
  localparam logic [1:0] K_CODE = ~J_CODE;
  logic [1:0] w_state, r_fsm, w_fsm_next;
  logic w_change, w_j, w_k, w_se0, w_rst_hit, w_susp_hit, w_leave_rst, w_leave_susp;
  logic [CNT_W-1:0] r_dur;
  logic [CNT_W:0] w_held;
  usb_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk(clk),
    .rst(rst),
    .i_line({usb_dp, usb_dn}),
    .o_state(w_state),
    .o_change(w_change)
  );
  // r_dur is cleared one edge after line_change, so w_held is the number of cycles
  // the current state has been shown before this one (prior state's length on a change)
  always_comb begin
    w_j = w_state == J_CODE;
    w_k = w_state == K_CODE;
    w_se0 = w_state == LS_SE0;
    w_held = {1'b0, r_dur} + (CNT_W+1)'(1);
    w_rst_hit = r_fsm == ST_SE0 && !w_change && int'(w_held) >= RESET_CYCLES;
    w_susp_hit = r_fsm == ST_ACTIVE && !w_change && w_j && int'(w_held) >= SUSPEND_CYCLES;
    w_leave_rst = w_change && !w_se0;
    w_leave_susp = w_change && (w_k || w_se0);
    w_fsm_next = r_fsm == ST_ACTIVE ? (w_change && w_se0 ? ST_SE0 : w_susp_hit ? ST_SUSPEND : ST_ACTIVE)
               : r_fsm == ST_SE0    ? (w_change ? ST_ACTIVE : w_rst_hit ? ST_RESET : ST_SE0)
               : r_fsm == ST_RESET  ? (w_leave_rst ? ST_ACTIVE : ST_RESET)
               : (w_change && w_k ? ST_ACTIVE : w_change && w_se0 ? ST_SE0 : ST_SUSPEND);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_fsm <= ST_SE0;
      r_dur <= '0;
    end else begin
      r_fsm <= w_fsm_next;
      r_dur <= w_change ? '0 : (r_dur == CNT_W'(SUSPEND_CYCLES) ? r_dur : r_dur + CNT_W'(1));
    end
  assign usb_line_state = w_state;
  assign line_j = w_j;
  assign line_k = w_k;
  assign line_se0 = w_se0;
  assign line_change = w_change;
  assign eop = r_fsm == ST_SE0 && w_change && w_j && int'(w_held) <= EOP_MAX_CYCLES;
  assign se1_err = w_change && w_state == LS_SE1;
  // levels rise with the detecting cycle and fall with the accepting cycle
  assign bus_reset = (r_fsm == ST_RESET && !w_leave_rst) || w_rst_hit;
  assign suspend = (r_fsm == ST_SUSPEND && !w_leave_susp) || w_susp_hit;
  assign resume = r_fsm == ST_SUSPEND && w_change && w_k;
endmodule

// File: tb/tb_usb_line_state_monitor.sv
// tb_usb_line_state_monitor: directed vectors with hand-computed expectations for FS and LS monitors
module tb_usb_line_state_monitor;
  import usb_phy_pkg::*;
  logic clk = 1'b0;
  logic rst, usb_dp, usb_dn;
  logic [1:0] usb_line_state, ls_state;
  logic line_j, line_k, line_se0, line_change, eop, se1_err, bus_reset, suspend, resume;
  logic ls_j, ls_k, ls_se0, ls_change, ls_eop, ls_se1, ls_bus_reset, ls_suspend, ls_resume;
  int n_vec = 0, n_err = 0;
  int n_eop = 0, n_change = 0, n_resume = 0, n_se1 = 0, n_eop_bad = 0;
  int c0, s0;
  always #5 clk = ~clk;
  usb_line_state_monitor #(
    .SYNC_STAGES(2), .FILTER_CYCLES(3), .LOW_SPEED(1'b0),
    .EOP_MAX_CYCLES(4), .RESET_CYCLES(16), .SUSPEND_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .usb_dp(usb_dp), .usb_dn(usb_dn),
    .usb_line_state(usb_line_state), .line_j(line_j), .line_k(line_k), .line_se0(line_se0),
    .line_change(line_change), .eop(eop), .se1_err(se1_err), .bus_reset(bus_reset),
    .suspend(suspend), .resume(resume)
  );
  usb_line_state_monitor #(
    .SYNC_STAGES(2), .FILTER_CYCLES(3), .LOW_SPEED(1'b1),
    .EOP_MAX_CYCLES(4), .RESET_CYCLES(16), .SUSPEND_CYCLES(64)
  ) dut_ls (
    .clk(clk), .rst(rst), .usb_dp(usb_dp), .usb_dn(usb_dn),
    .usb_line_state(ls_state), .line_j(ls_j), .line_k(ls_k), .line_se0(ls_se0),
    .line_change(ls_change), .eop(ls_eop), .se1_err(ls_se1), .bus_reset(ls_bus_reset),
    .suspend(ls_suspend), .resume(ls_resume)
  );
  always @(negedge clk)
    if (!rst) begin
      n_eop <= n_eop + int'(eop);
      n_change <= n_change + int'(line_change);
      n_resume <= n_resume + int'(resume);
      n_se1 <= n_se1 + int'(se1_err);
      if (eop && !(line_change && line_j)) n_eop_bad <= n_eop_bad + 1;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drive(input logic dp, input logic dn);
    usb_dp = dp;
    usb_dn = dn;
  endtask
  task automatic eop_run(input int len, input int exp);
    int e0;
    e0 = n_eop;
    drive(1'b0, 1'b0);
    ticks(len);
    drive(1'b1, 1'b0);
    ticks(8);
    chk($sformatf("eop_se0_len_%0d", len), n_eop - e0, exp);
    chk($sformatf("eop_back_to_j_%0d", len), usb_line_state, LS_DP);
  endtask
  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0);
    ticks(3);
    chk("rst_state", usb_line_state, LS_SE0);
    chk("rst_se0", line_se0, 1);
    chk("rst_j", line_j, 0);
    chk("rst_k", line_k, 0);
    chk("rst_change", line_change, 0);
    chk("rst_bus_reset", bus_reset, 0);
    chk("rst_suspend", suspend, 0);
    // J from reset: accepted on the 5th edge
    rst = 1'b0;
    drive(1'b1, 1'b0);
    ticks(4);
    chk("lat_4_state", usb_line_state, LS_SE0);
    chk("lat_4_change", n_change, 0);
    ticks(1);
    chk("lat_5_state", usb_line_state, LS_DP);
    chk("lat_5_j", line_j, 1);
    chk("lat_5_change", line_change, 1);
    chk("ls_k", ls_k, 1);
    chk("ls_j", ls_j, 0);
    ticks(1);
    chk("change_one_cycle", line_change, 0);
    chk("no_eop_from_reset", n_eop, 0);
    // 2-cycle glitch is filtered out
    c0 = n_change;
    drive(1'b0, 1'b0);
    ticks(2);
    drive(1'b1, 1'b0);
    ticks(8);
    chk("glitch_change", n_change - c0, 0);
    chk("glitch_state", usb_line_state, LS_DP);
    eop_run(3, 1);
    eop_run(4, 1);
    eop_run(5, 0);
    eop_run(6, 0);
    chk("eop_aligned", n_eop_bad, 0);
    // long SE0 -> bus reset after 16 accepted cycles
    s0 = n_eop;
    drive(1'b0, 1'b0);
    ticks(5);
    chk("br_se0_acc", line_se0, 1);
    ticks(15);
    chk("br_k15", bus_reset, 0);
    ticks(1);
    chk("br_k16", bus_reset, 1);
    ticks(4);
    chk("br_held", bus_reset, 1);
    drive(1'b1, 1'b0);
    ticks(4);
    chk("br_before_j", bus_reset, 1);
    ticks(1);
    chk("br_exit_j", line_j, 1);
    chk("br_exit_level", bus_reset, 0);
    chk("br_no_eop", n_eop - s0, 0);
    // idle J -> suspend after 64 cycles, K -> resume
    ticks(63);
    chk("susp_k63", suspend, 0);
    ticks(1);
    chk("susp_k64", suspend, 1);
    ticks(6);
    chk("susp_held", suspend, 1);
    s0 = n_resume;
    drive(1'b0, 1'b1);
    ticks(4);
    chk("res_before_k", resume, 0);
    ticks(1);
    chk("res_pulse", resume, 1);
    chk("res_k", line_k, 1);
    chk("res_susp_drop", suspend, 0);
    ticks(1);
    chk("res_one", n_resume - s0, 1);
    chk("res_fsm_active", dut.r_fsm, ST_ACTIVE);
    // SE1 entry
    s0 = n_se1;
    drive(1'b1, 1'b1);
    ticks(5);
    chk("se1_pulse", se1_err, 1);
    chk("se1_state", usb_line_state, LS_SE1);
    ticks(1);
    chk("se1_once", n_se1 - s0, 1);
    // reset mid-SE0 count
    drive(1'b0, 1'b0);
    ticks(13);
    chk("mid_se0_no_br", bus_reset, 0);
    drive(1'b1, 1'b1);
    ticks(2);
    rst = 1'b1;
    #1;
    chk("arst_state", usb_line_state, LS_SE0);
    chk("arst_se0", line_se0, 1);
    chk("arst_change", line_change, 0);
    chk("arst_se1", se1_err, 0);
    chk("arst_br", bus_reset, 0);
    drive(1'b0, 1'b0);
    ticks(2);
    c0 = n_change;
    rst = 1'b0;
    ticks(14);
    chk("post_rst_change", n_change - c0, 0);
    chk("post_rst_br_14", bus_reset, 0);
    ticks(1);
    chk("post_rst_br_15", bus_reset, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
